factorial_core: RTL
===================

Name: factorial_core

Overview:
Datapath/compute stage that sits directly downstream of the memory-mapped factorial register controller. It consumes that controller's start, clear, interrupt-enable and operand outputs and computes operand! by iterated sequential multiplication. It returns the status and 128-bit result (high/low 64-bit words) that the controller exposes for readback, and raises an interrupt on completion.

Parameters:
OPR_W, 64, operand width; one multiply step takes OPR_W cycles
RES_W, 128, result width (2*OPR_W); result split into result_h/result_l

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
op_start  in  1  level from controller; a rising edge starts a computation
op_clear  in  1  level; synchronous abort/clear while high
intr_en  in  1  interrupt enable
operand  in  OPR_W  N, the value whose factorial is computed
op_done  out  2  bit0 = done; bit1 = overflow (0 when feature is compiled out)
result_h  out  64  result[127:64]
result_l  out  64  result[63:0]
busy  out  1  high in every state except IDLE and DONE
intr  out  1  intr_en & op_done[0], combinational

Behaviour:
- Reset state: IDLE; result, done, overflow and start_d all 0; busy=0; intr=0.
- Start detect: start_d <= op_start each cycle. start_edge = op_start & ~start_d.
- FSM states: IDLE, LOAD, MUL, CHK, DONE.
- IDLE, or DONE, with start_edge: go to LOAD, latch operand into n_r, clear done and overflow. A restart from DONE is legal.
- LOAD (1 cycle):
  - If n_r < 3: result = (n_r==0 ? 1 : n_r) and go to DONE.
  - Otherwise: mcand = n_r (zero-extended to RES_W), mplier = n_r-1, count = n_r-1, go to MUL.
- MUL: the multiplier runs a radix-2 shift-add of mcand x mplier for exactly OPR_W cycles. The product is truncated to RES_W.
- CHK (1 cycle):
  - result = product, count = count-1.
  - If the new count < 2: go to DONE.
  - Otherwise: mcand = product, mplier = new count, go to MUL.
- DONE: op_done[0]=1 and the result is held until the next start_edge or op_clear.
- Latency, counted in rising edges after the edge that samples start_edge:
  - N<=2: done visible after 2 edges.
  - N>=3: done visible after 2 + (OPR_W+1)*(N-2) edges.
- start_edge while busy (LOAD/MUL/CHK): ignored. The edge is consumed because start_d updates anyway.
- op_clear high (highest priority after reset): next edge goes to IDLE, zeroes result, done, overflow and the multiplier. This applies in any state, including mid-MUL. A start_edge in the same cycle is dropped.
- reset mid-operation: immediate return to the reset state, no partial result retained.
- Operand is sampled only at LOAD; later operand changes have no effect.
- Results for N>34 are the true value mod 2^128.

Optional Feature:
FACT_OVF_DETECT_EN
- Defined: the multiplier also tracks carry-out beyond RES_W. Overflow is set sticky in CHK if any product bit >= RES_W is nonzero. op_done[1] = overflow, cleared on start_edge, op_clear or reset.
- Undefined: no overflow logic is built and op_done[1] is tied to 0.
- Results and latency are identical in both builds.

Decomposition:
- Package fact_pkg:
  - FSM state enum (IDLE, LOAD, MUL, CHK, DONE).
  - OPR_W/RES_W defaults.
  - op_done bit-index constants (DONE_BIT=0, OVF_BIT=1).
- Sub-module fact_mul_seq: sequential shift-add multiplier.
  - Inputs: clk, reset, clr, go, mcand[RES_W], mplier[OPR_W].
  - Outputs: product[RES_W], ovf, valid.
  - valid is a 1-cycle pulse exactly OPR_W cycles after go.

Test Plan:
- operand=5, pulse op_start -> done after 197 edges; result_h=0, result_l=0x78; busy high throughout; intr=0 while intr_en=0.
- operand=0 then operand=1 (each restarted from DONE) -> done after 2 edges each; result_l=0x1, result_h=0.
- operand=21, intr_en=1 -> result_h=0x2, result_l=0xC5077D36B8C40000; intr rises with done.
- operand=34 then 35 (FACT_OVF_DETECT_EN defined) -> op_done=2'b01 for 34; op_done=2'b11 for 35. Undefined build -> op_done=2'b01 both.
- operand=10, assert op_clear for 1 cycle mid-MUL -> next edge: IDLE, result=0, done=0, busy=0. A subsequent start with operand=3 -> result_l=0x6.
- operand=6 running; second op_start rising edge plus operand=3 during MUL -> ignored; final result_l=0x2D0 (720).

Source files
------------

// File: rtl/fact_pkg.sv
// Shared types and constants for the factorial datapath.
// Optional overflow tracking is enabled by defining FACT_OVF_DETECT_EN.
package fact_pkg;

    localparam int OPR_W_DEF = 64;
    localparam int RES_W_DEF = 128;

    localparam int DONE_BIT = 0;
    localparam int OVF_BIT  = 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MUL,
        CHK,
        DONE
    } state_t;

endpackage

// File: rtl/fact_mul_seq.sv
// Radix-2 shift-add multiplier, one multiplier bit per cycle for OPR_W cycles.
// With FACT_OVF_DETECT_EN the accumulator is widened so carries past RES_W are seen.
module fact_mul_seq
    import fact_pkg::*;
#(
    parameter int OPR_W = OPR_W_DEF,
    parameter int RES_W = RES_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             go,
    input  logic [RES_W-1:0] mcand,
    input  logic [OPR_W-1:0] mplier,
    output logic [RES_W-1:0] product,
    output logic             ovf,
    output logic             valid
);

`ifdef FACT_OVF_DETECT_EN
    localparam int ACC_W = RES_W + OPR_W;
`else
    localparam int ACC_W = RES_W;
`endif
    localparam int CNT_W = $clog2(OPR_W + 1);

    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] mc_reg;
    logic [OPR_W-1:0] mp_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg <= '0;
            mc_reg  <= '0;
            mp_reg  <= '0;
            cnt_reg <= '0;
        end else if (clr) begin
            acc_reg <= '0;
            mc_reg  <= '0;
            mp_reg  <= '0;
            cnt_reg <= '0;
        end else if (go) begin
            acc_reg <= '0;
            mc_reg  <= ACC_W'(mcand);
            mp_reg  <= mplier;
            cnt_reg <= CNT_W'(OPR_W);
        end else if (cnt_reg != '0) begin
            if (mp_reg[0]) begin
                acc_reg <= acc_reg + mc_reg;
            end
            mc_reg  <= mc_reg << 1;
            mp_reg  <= mp_reg >> 1;
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
    end

    // valid marks the final step: product is complete on the following cycle,
    // which is exactly when the controller sits in CHK and consumes it.
    assign valid   = (cnt_reg == CNT_W'(1));
    assign product = acc_reg[RES_W-1:0];

`ifdef FACT_OVF_DETECT_EN
    assign ovf = |acc_reg[ACC_W-1:RES_W];
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/factorial_core.sv
// Iterative factorial engine: N! via repeated sequential multiplies.
// Define FACT_OVF_DETECT_EN to report a sticky overflow in op_done[1].
module factorial_core
    import fact_pkg::*;
#(
    parameter int OPR_W = OPR_W_DEF,
    parameter int RES_W = RES_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_start,
    input  logic             op_clear,
    input  logic             intr_en,
    input  logic [OPR_W-1:0] operand,
    output logic [1:0]       op_done,
    output logic [63:0]      result_h,
    output logic [63:0]      result_l,
    output logic             busy,
    output logic             intr
);

    state_t           state_reg, state_next;
    logic             start_d_reg;
    logic [OPR_W-1:0] n_reg;
    logic [OPR_W-1:0] count_reg;
    logic [RES_W-1:0] result_reg;
    logic             done_reg;

    logic             start_edge;
    logic [OPR_W-1:0] count_dec;
    logic             mul_go;
    logic [RES_W-1:0] mul_mcand;
    logic [OPR_W-1:0] mul_mplier;
    logic [RES_W-1:0] mul_product;
    logic             mul_ovf;
    logic             mul_valid;

    assign start_edge = op_start & ~start_d_reg;
    assign count_dec  = count_reg - OPR_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mul_go     = 1'b0;
        mul_mcand  = '0;
        mul_mplier = '0;
        if (op_clear) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: if (start_edge) state_next = LOAD;
                LOAD: begin
                    if (n_reg < OPR_W'(3)) begin
                        state_next = DONE;
                    end else begin
                        state_next = MUL;
                        mul_go     = 1'b1;
                        mul_mcand  = RES_W'(n_reg);
                        mul_mplier = n_reg - OPR_W'(1);
                    end
                end
                MUL:  if (mul_valid) state_next = CHK;
                CHK: begin
                    if (count_dec < OPR_W'(2)) begin
                        state_next = DONE;
                    end else begin
                        state_next = MUL;
                        mul_go     = 1'b1;
                        mul_mcand  = mul_product;
                        mul_mplier = count_dec;
                    end
                end
                DONE: if (start_edge) state_next = LOAD;
                default: state_next = IDLE;
            endcase
        end
    end

    // done is set one cycle after entering DONE, so a restart that lands on
    // that first DONE cycle never shows a stale done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_d_reg <= 1'b0;
            n_reg       <= '0;
            count_reg   <= '0;
            result_reg  <= '0;
            done_reg    <= 1'b0;
        end else begin
            start_d_reg <= op_start;
            if (op_clear) begin
                result_reg <= '0;
                done_reg   <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start_edge) begin
                            n_reg    <= operand;
                            done_reg <= 1'b0;
                        end
                    end
                    LOAD: begin
                        if (n_reg < OPR_W'(3)) begin
                            result_reg <= (n_reg == '0) ? RES_W'(1) : RES_W'(n_reg);
                        end else begin
                            count_reg <= n_reg - OPR_W'(1);
                        end
                    end
                    CHK: begin
                        result_reg <= mul_product;
                        count_reg  <= count_dec;
                    end
                    DONE: begin
                        if (start_edge) begin
                            n_reg    <= operand;
                            done_reg <= 1'b0;
                        end else begin
                            done_reg <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef FACT_OVF_DETECT_EN
    logic ovf_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_reg <= 1'b0;
        end else if (op_clear) begin
            ovf_reg <= 1'b0;
        end else if (start_edge && (state_reg == IDLE || state_reg == DONE)) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == CHK) begin
            ovf_reg <= ovf_reg | mul_ovf;
        end
    end

    assign op_done[OVF_BIT] = ovf_reg;
`else
    logic ovf_unused;
    assign ovf_unused       = mul_ovf;
    assign op_done[OVF_BIT] = 1'b0;
`endif

    fact_mul_seq #(
        .OPR_W (OPR_W),
        .RES_W (RES_W)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .clr     (op_clear),
        .go      (mul_go),
        .mcand   (mul_mcand),
        .mplier  (mul_mplier),
        .product (mul_product),
        .ovf     (mul_ovf),
        .valid   (mul_valid)
    );

    assign op_done[DONE_BIT] = done_reg;
    assign result_h          = result_reg[RES_W-1 -: 64];
    assign result_l          = result_reg[63:0];
    assign busy              = (state_reg != IDLE) && (state_reg != DONE);
    assign intr              = intr_en & op_done[DONE_BIT];

endmodule
